// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// hazard_fwd_unit : ID-side RAW stall/flush control and EX forwarding selects
// Revision 1.0 - initial release
// ============================================================================
module hazard_fwd_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [REG_AW-1:0]         id_dst_addr_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_mem_read_i,
  input  logic                      br_taken_i,
  output logic                      stall_o,
  output logic                      flush_o,
  output logic [2*NUM_SRC-1:0]      ex_fwd_sel_o,
  output logic [CNT_W-1:0]          stall_count_o,
  output logic [CNT_W-1:0]          flush_count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A WB producer never needs a stall or a bypass (the register file writes
  // before it is read), so only the EX and MEM occupants are tracked here.
  logic                 ex_wr_q, ex_wr_d;
  logic                 ex_ld_q, ex_ld_d;
  logic [REG_AW-1:0]    ex_dst_q, ex_dst_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [REG_AW-1:0]    mem_dst_q, mem_dst_d;
  logic [2*NUM_SRC-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;

  logic [NUM_SRC-1:0]   hit_ex;
  logic [NUM_SRC-1:0]   hit_mem;
  logic                 hazard;
  logic                 issue;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              live;
    assign src        = id_src_addr_i[k*REG_AW +: REG_AW];
    assign live       = id_src_used_i[k] && (src != '0);
    assign hit_ex[k]  = live && ex_wr_q  && (ex_dst_q  == src);
    assign hit_mem[k] = live && mem_wr_q && (mem_dst_q == src);

    if (FWD_EN != 0) begin : g_fwd_sel
      assign sel_d[2*k +: 2] = !issue      ? 2'b00 :
                               hit_ex[k]   ? 2'b01 :
                               hit_mem[k]  ? 2'b10 : 2'b00;
    end else begin : g_nofwd_sel
      assign sel_d[2*k +: 2] = 2'b00;
    end
  end

  if (FWD_EN != 0) begin : g_fwd_haz
    assign hazard = (|hit_ex) && ex_ld_q;
  end else begin : g_nofwd_haz
    assign hazard = |(hit_ex | hit_mem);
  end

  // Flush wins over stall; a bubble in ID never stalls.
  assign stall_o = id_valid_i && !br_taken_i && hazard;
  assign flush_o = br_taken_i;
  assign issue   = id_valid_i && !stall_o && !br_taken_i;

  assign ex_wr_d   = issue && id_reg_write_i;
  assign ex_ld_d   = issue && id_mem_read_i;
  assign ex_dst_d  = issue ? id_dst_addr_i : '0;
  assign mem_wr_d  = ex_wr_q && !br_taken_i;
  assign mem_dst_d = ex_dst_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_dst_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_dst_q   <= '0;
      sel_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_wr_q   <= ex_wr_d;
      ex_ld_q   <= ex_ld_d;
      ex_dst_q  <= ex_dst_d;
      mem_wr_q  <= mem_wr_d;
      mem_dst_q <= mem_dst_d;
      sel_q     <= sel_d;
      if (stall_o && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (flush_o && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign ex_fwd_sel_o  = sel_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard-detection and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It sits beside the decode stage and keeps its own shadow scoreboard of in-flight destination registers for EX, MEM and WB. From that scoreboard it produces:
- the IF/ID hold (stall),
- the branch flush,
- registered EX-stage forwarding selects for every source operand.

It also counts stall and flush events for performance debug.

## Interface
Parameters:
- REG_AW, 5, register address width (2**REG_AW registers; address 0 hard-wired zero)
- NUM_SRC, 2, number of source operands checked per instruction
- FWD_EN, 1, 1 = forwarding mode (stall only on load-use); 0 = no-forward mode (stall on any RAW to EX/MEM producer)
- CNT_W, 16, width of the saturating event counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  instruction in ID is real (0 = bubble)
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses, operand k at [k*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  operand k is actually read
- id_dst_addr  in  REG_AW  destination of the ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- br_taken  in  1  branch resolved taken by the instruction now in MEM
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX (combinational)
- flush  out  1  kill IF/ID, ID/EX and EX/MEM contents (combinational, equals br_taken)
- ex_fwd_sel  out  2*NUM_SRC  registered per-operand select for the instruction in EX: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data, 11 never driven
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of flush cycles

## Operation
- Scoreboard: three slots (EX, MEM, WB), each {valid, dst, reg_write, mem_read}. Every cycle MEM→WB and EX→MEM shift unconditionally. EX loads the ID entry, or a bubble (valid=0) when stall or flush is asserted or id_valid=0.
- Flush: when br_taken=1, the entry shifting EX→MEM and the entry entering EX are both written invalid. The MEM→WB shift (the branch itself) is unaffected.
- Match definition: operand k matches slot S when all of the following hold: id_src_used[k], S.valid, S.reg_write, S.dst == src_k, src_k != 0.
- Stall, FWD_EN=1: asserted when any operand matches EX and EX.mem_read=1 (load-use, one cycle).
- Stall, FWD_EN=0: asserted when any operand matches EX or MEM. A WB producer never stalls, because the register file writes before it is read.
- Stall is gated by id_valid. br_taken forces stall=0, so flush wins.
- Forward select, computed in ID and registered into ex_fwd_sel on the clock edge:
  - match EX → 01 (priority, youngest producer)
  - else match MEM → 10
  - else 00
  - With FWD_EN=0, all selects are 00.
  - When stall, flush or !id_valid, the registered value is all zeros.
- Counters: increment by 1 on each cycle with stall=1 (stall_count) or flush=1 (flush_count). They saturate at 2**CNT_W-1 and do not wrap.

## Timing
- Reset (reset=0 at a clock edge): all slots invalid, ex_fwd_sel=0, both counters=0. stall=0 and flush=br_taken combinationally from the next cycle onward, because the scoreboard is empty.
- Reset asserted mid-stall: scoreboard is cleared, so stall drops in the cycle after the reset edge.
- stall and flush have zero latency (same cycle as inputs).
- ex_fwd_sel has 1-cycle latency and is valid while the consumer occupies EX.
- Load-use with FWD_EN=1: stall for exactly 1 cycle. The next cycle the load is in MEM, and the consumer leaves ID with select 10.
- RAW distance 1 with FWD_EN=0: stall for 2 cycles. Distance 2: stall for 1 cycle.
- br_taken and a load-use hazard in the same cycle: stall=0, flush=1, flush_count increments, stall_count does not.
- Multiple operands hitting different slots: each operand is resolved independently.

## Test plan
- Load-use: lw r3 in ID, then add r4,r3,r5 → 1 cycle stall=1; next cycle ex_fwd_sel[1:0]=00 with stall=0; the cycle after, ex_fwd_sel[1:0]=10; stall_count=1.
- Back-to-back ALU: add r1 then sub r2,r1,r1 (FWD_EN=1) → stall=0, ex_fwd_sel=0101 one cycle after sub is in ID. Distance 2 gives 1010. Distance 3 gives 0000.
- Register 0: add r0 then add r2,r0,r0 → no stall, ex_fwd_sel=0000.
- Branch: br_taken=1 while a load-use is pending → flush=1 and stall=0 that cycle. The following consumer sees no forwarding from the killed slots. flush_count=1.
- No-forward mode (FWD_EN=0): add r1 then add r2,r1,r0 → stall=1 for 2 cycles, then proceed with ex_fwd_sel=0000; stall_count=2.
- Reset and saturation: CNT_W=2 with 5 consecutive stalls → stall_count=3. Then reset=0 mid-stall → all outputs 0 next cycle, and stall=0 even with hazard inputs held.
